// File: rtl/dso100fb_pkg.sv
// Shared constants for the framebuffer page controller: register map, CTRL bits,
// sequencer states and the end-address helper.
package dso100fb_pkg;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_BUF0_BASE = 2'd1;
  localparam logic [1:0] REG_BUF1_BASE = 2'd2;
  localparam logic [1:0] REG_FB_SIZE   = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLIP   = 1;
  localparam int CTRL_FRONT  = 2;
  localparam int CTRL_IRQ    = 3;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Last word address of a buffer; wraps modulo 2^32.
  function automatic logic [31:0] fb_end_addr(input logic [31:0] base,
                                              input logic [31:0] size);
    logic [31:0] sum;
    sum = base + size - 32'd4;
    return {sum[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dso100fb_page_ctrl_if.sv
// CPU register bus for the page controller: single-cycle write/read strobes,
// registered read data.
interface dso100fb_page_ctrl_if;
  logic        REG_WRITE;
  logic        REG_READ;
  logic [1:0]  REG_ADDR;
  logic [31:0] REG_WDATA;
  logic [31:0] REG_RDATA;

  modport master (output REG_WRITE, REG_READ, REG_ADDR, REG_WDATA,
                  input  REG_RDATA);
  modport slave  (input  REG_WRITE, REG_READ, REG_ADDR, REG_WDATA,
                  output REG_RDATA);
endinterface

// File: rtl/dso100fb_page_regs.sv
// Register file for the page controller: CTRL/base/size storage, read mux,
// FLIP pending and front index. IRQ bit exists only with DSO100FB_FLIP_IRQ_EN.
module dso100fb_page_regs
  import dso100fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        flip_take,
  input  logic        irq_set,
  output logic        enable,
  output logic        pending,
  output logic        front,
  output logic        irq,
  output logic [31:0] buf0,
  output logic [31:0] buf1,
  output logic [31:0] fb_size,
  output logic        go_eff
);

  logic        enable_q, enable_d;
  logic        pending_q, pending_d;
  logic        front_q, front_d;
  logic [31:0] buf0_q, buf0_d;
  logic [31:0] buf1_q, buf1_d;
  logic [31:0] size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ctrl_wr;

  assign ctrl_wr = wr && (addr == REG_CTRL);

  always_comb begin
    enable_d = enable_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    size_d   = size_q;
    if (ctrl_wr)                           enable_d = wdata[CTRL_ENABLE];
    if (wr && addr == REG_BUF0_BASE)       buf0_d   = {wdata[31:2], 2'b00};
    if (wr && addr == REG_BUF1_BASE)       buf1_d   = {wdata[31:2], 2'b00};
    if (wr && addr == REG_FB_SIZE)         size_d   = {wdata[31:2], 2'b00};
  end

  // Stop decisions see a same-cycle write so ENABLE/FB_SIZE clears act at once.
  assign go_eff = enable_d && (size_d != 32'd0);

  // A FLIP write wins over a same-cycle take: it is kept for the next VSYNC.
  always_comb begin
    pending_d = (pending_q & ~flip_take) | (ctrl_wr & wdata[CTRL_FLIP]);
    front_d   = front_q ^ flip_take;
  end

`ifdef DSO100FB_FLIP_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_set | (irq_q & ~(ctrl_wr & wdata[CTRL_IRQ]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_set;
  assign unused_irq_set = irq_set;
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        REG_CTRL:      rdata_d = {28'd0, irq, front_q, pending_q, enable_q};
        REG_BUF0_BASE: rdata_d = buf0_q;
        REG_BUF1_BASE: rdata_d = buf1_q;
        default:       rdata_d = size_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
      front_q   <= 1'b0;
      buf0_q    <= 32'd0;
      buf1_q    <= 32'd0;
      size_q    <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      front_q   <= front_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      size_q    <= size_d;
      rdata_q   <= rdata_d;
    end
  end

  assign enable  = enable_q;
  assign pending = pending_q;
  assign front   = front_q;
  assign buf0    = buf0_q;
  assign buf1    = buf1_q;
  assign fb_size = size_q;
  assign rdata   = rdata_q;

endmodule

// File: rtl/dso100fb_page_ctrl.sv
// Framebuffer page controller: restarts the fetch engine at VSYNC for tear-free
// flips. Optional flip interrupt enabled by defining DSO100FB_FLIP_IRQ_EN.
module dso100fb_page_ctrl
  import dso100fb_pkg::*;
#(
  parameter int RESTART_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  dso100fb_page_ctrl_if.slave  REG_BUS,
  input  logic                 VSYNC,
  output logic                 FETCH_EN,
  output logic [31:0]          FETCH_FB_BASE,
  output logic [31:0]          FETCH_FB_END,
  output logic                 FIFO_FLUSH,
  output logic                 IRQ_FLIP
);

  localparam logic [3:0] CNT_LOAD = 4'(RESTART_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] fb_base_q, fb_base_d;
  logic [31:0] fb_end_q, fb_end_d;

  logic        flip_take, irq_set, load, sel;
  logic        enable, pending, front, irq, go_eff;
  logic [31:0] buf0, buf1, fb_size;

  dso100fb_page_regs u_regs (
    .clk       (CLK),
    .rst_n     (RST_N),
    .wr        (REG_BUS.REG_WRITE),
    .rd        (REG_BUS.REG_READ),
    .addr      (REG_BUS.REG_ADDR),
    .wdata     (REG_BUS.REG_WDATA),
    .rdata     (REG_BUS.REG_RDATA),
    .flip_take (flip_take),
    .irq_set   (irq_set),
    .enable    (enable),
    .pending   (pending),
    .front     (front),
    .irq       (irq),
    .buf0      (buf0),
    .buf1      (buf1),
    .fb_size   (fb_size),
    .go_eff    (go_eff)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fb_base_d = fb_base_q;
    fb_end_d  = fb_end_q;
    flip_take = 1'b0;
    irq_set   = 1'b0;
    load      = 1'b0;
    sel       = front;
    case (state_q)
      ST_OFF: begin
        // Start only on settled register values; a flip queued while off is silent.
        if (enable && fb_size != 32'd0 && go_eff) begin
          flip_take = pending;
          load      = 1'b1;
          state_d   = ST_RESTART;
        end
      end
      ST_RESTART: begin
        if (!go_eff)            state_d = ST_OFF;
        else if (cnt_q == 4'd0) state_d = ST_RUN;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      ST_RUN: begin
        if (!go_eff) begin
          state_d = ST_OFF;
        end else if (VSYNC && pending) begin
          flip_take = 1'b1;
          irq_set   = 1'b1;
          load      = 1'b1;
          state_d   = ST_RESTART;
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Addresses latch only on RESTART entry, so later writes wait for the next one.
    if (load) begin
      sel       = flip_take ? ~front : front;
      fb_base_d = sel ? buf1 : buf0;
      fb_end_d  = fb_end_addr(fb_base_d, fb_size);
      cnt_d     = CNT_LOAD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_OFF;
      cnt_q     <= 4'd0;
      fb_base_q <= 32'd0;
      fb_end_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fb_base_q <= fb_base_d;
      fb_end_q  <= fb_end_d;
    end
  end

  assign FETCH_EN      = (state_q == ST_RUN);
  assign FIFO_FLUSH    = (state_q == ST_RESTART);
  assign FETCH_FB_BASE = fb_base_q;
  assign FETCH_FB_END  = fb_end_q;
  assign IRQ_FLIP      = irq;

endmodule

// File: tb/tb_dso100fb_page_ctrl.sv
// Directed bench for dso100fb_page_ctrl; register reads checked through a
// scoreboard queue. Honors DSO100FB_FLIP_IRQ_EN for IRQ expectations.
module tb_dso100fb_page_ctrl;

`ifdef DSO100FB_FLIP_IRQ_EN
  localparam logic [31:0] IRQB = 32'h8;
  localparam logic        IRQ1 = 1'b1;
`else
  localparam logic [31:0] IRQB = 32'h0;
  localparam logic        IRQ1 = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        VSYNC = 1'b0;
  logic        FETCH_EN, FIFO_FLUSH, IRQ_FLIP;
  logic [31:0] FETCH_FB_BASE, FETCH_FB_END;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];

  dso100fb_page_ctrl_if bus();

  dso100fb_page_ctrl #(.RESTART_CYCLES(4)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .REG_BUS       (bus),
    .VSYNC         (VSYNC),
    .FETCH_EN      (FETCH_EN),
    .FETCH_FB_BASE (FETCH_FB_BASE),
    .FETCH_FB_END  (FETCH_FB_END),
    .FIFO_FLUSH    (FIFO_FLUSH),
    .IRQ_FLIP      (IRQ_FLIP)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.REG_WRITE = 1'b1;
    bus.REG_ADDR  = a;
    bus.REG_WDATA = d;
    tick();
    bus.REG_WRITE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.REG_READ = 1'b1;
    bus.REG_ADDR = a;
    sb_q.push_back(exp);
    tick();
    bus.REG_READ = 1'b0;
    chk(tag, bus.REG_RDATA, sb_q.pop_front());
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
  endtask

  // Waits (bounded) for a flush window, measures it, then checks fetch restarts.
  task automatic measure_restart(input string tag);
    int w, n;
    logic en_seen;
    w = 0;
    while (!FIFO_FLUSH && w < 10) begin tick(); w++; end
    chkb({tag, "_flush_start"}, FIFO_FLUSH, 1'b1);
    n = 0;
    en_seen = 1'b0;
    while (FIFO_FLUSH && n < 20) begin
      en_seen = en_seen | FETCH_EN;
      n++;
      tick();
    end
    chkb({tag, "_en_during_flush"}, en_seen, 1'b0);
    chk({tag, "_flush_len"}, 32'(n), 32'd4);
    chkb({tag, "_fetch_en"}, FETCH_EN, 1'b1);
  endtask

  initial begin
    bus.REG_WRITE = 1'b0;
    bus.REG_READ  = 1'b0;
    bus.REG_ADDR  = 2'd0;
    bus.REG_WDATA = 32'd0;
    #2;
    chkb("rst_fetch_en", FETCH_EN, 1'b0);
    chkb("rst_flush", FIFO_FLUSH, 1'b0);
    chk("rst_base", FETCH_FB_BASE, 32'd0);
    chk("rst_end", FETCH_FB_END, 32'd0);
    chkb("rst_irq", IRQ_FLIP, 1'b0);
    chk("rst_rdata", bus.REG_RDATA, 32'd0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Basic start-up from buffer 0; low address bits are dropped
    wr(2'd1, 32'h2000_0003);
    wr(2'd3, 32'h000B_B802);
    rd("buf0_rb", 2'd1, 32'h2000_0000);
    rd("size_rb", 2'd3, 32'h000B_B800);
    tick();
    chk("rdata_hold", bus.REG_RDATA, 32'h000B_B800);
    wr(2'd0, 32'h1);
    measure_restart("start");
    chk("start_base", FETCH_FB_BASE, 32'h2000_0000);
    chk("start_end", FETCH_FB_END, 32'h200B_B7FC);

    // Flip to buffer 1 at VSYNC
    wr(2'd2, 32'h2010_0000);
    wr(2'd0, 32'h3);
    tick();
    chkb("pre_vsync_running", FETCH_EN, 1'b1);
    vsync_pulse();
    measure_restart("flip1");
    chk("flip1_base", FETCH_FB_BASE, 32'h2010_0000);
    chk("flip1_end", FETCH_FB_END, 32'h201B_B7FC);
    rd("flip1_ctrl", 2'd0, 32'h5 | IRQB);
    chkb("flip1_irq", IRQ_FLIP, IRQ1);
    wr(2'd0, 32'h9);
    chkb("irq_clear", IRQ_FLIP, 1'b0);

    // FLIP written in the same cycle as VSYNC waits for the next VSYNC
    bus.REG_WRITE = 1'b1;
    bus.REG_ADDR  = 2'd0;
    bus.REG_WDATA = 32'h3;
    VSYNC = 1'b1;
    tick();
    bus.REG_WRITE = 1'b0;
    VSYNC = 1'b0;
    chkb("same_cyc_no_restart", FIFO_FLUSH, 1'b0);
    tick(); tick();
    chkb("same_cyc_still_run", FETCH_EN, 1'b1);
    rd("same_cyc_ctrl", 2'd0, 32'h7);
    vsync_pulse();
    measure_restart("flip2");
    chk("flip2_base", FETCH_FB_BASE, 32'h2000_0000);
    rd("flip2_ctrl", 2'd0, 32'h1 | IRQB);

    // ENABLE cleared in RESTART cycle 2
    wr(2'd0, 32'h3);
    vsync_pulse();
    chkb("abort_flush_c1", FIFO_FLUSH, 1'b1);
    tick();
    wr(2'd0, 32'h0);
    chkb("abort_flush_drop", FIFO_FLUSH, 1'b0);
    chkb("abort_en_low", FETCH_EN, 1'b0);
    tick(); tick(); tick();
    chkb("abort_stay_off", FETCH_EN | FIFO_FLUSH, 1'b0);
    rd("abort_ctrl", 2'd0, 32'h4 | IRQB);
    wr(2'd0, 32'h8);
    chkb("abort_irq_clear", IRQ_FLIP, 1'b0);

    // Zero size keeps the fetch engine off until a size arrives
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 10; i++) tick();
    chkb("zero_size_off", FETCH_EN | FIFO_FLUSH, 1'b0);
    wr(2'd3, 32'h100);
    measure_restart("size100");
    chk("size100_base", FETCH_FB_BASE, 32'h2010_0000);
    chk("size100_end", FETCH_FB_END, 32'h2010_00FC);
    wr(2'd2, 32'h3000_0000);
    tick();
    chk("shadow_base", FETCH_FB_BASE, 32'h2010_0000);

    // Asynchronous reset while running
    RST_N = 1'b0;
    #2;
    chkb("arst_fetch_en", FETCH_EN, 1'b0);
    chk("arst_base", FETCH_FB_BASE, 32'd0);
    chk("arst_end", FETCH_FB_END, 32'd0);
    chkb("arst_flush", FIFO_FLUSH, 1'b0);
    chkb("arst_irq", IRQ_FLIP, 1'b0);
    tick();
    RST_N = 1'b1;
    rd("arst_ctrl", 2'd0, 32'h0);
    rd("arst_buf0", 2'd1, 32'h0);
    rd("arst_buf1", 2'd2, 32'h0);
    rd("arst_size", 2'd3, 32'h0);
    chkb("arst_stay_off", FETCH_EN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
